// File: rtl/escalonador_quantum.sv
// Preemptive round-robin scheduler: counts retired instructions against a quantum and
// redirects the PC to the context-switch routine when the running program must give way.
module escalonador_quantum #(
    parameter int unsigned NUM_PROC   = 5,
    parameter int unsigned QUANTUM    = 16,
    parameter int unsigned BASE_PROG  = 2000,
    parameter int unsigned PASSO      = 1000,
    parameter int unsigned END_TROCA  = 0,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  habilita,
    input  logic [NUM_PROC-1:0]   proc_ativo,
    input  logic                  instr_exec,
    input  logic                  proc_fim,
    input  logic                  troca_ack,
    output logic                  desvio,
    output logic [ADDR_WIDTH-1:0] endereco_desvio,
    output logic                  troca_req,
    output logic [2:0]            proc_atual,
    output logic [2:0]            proc_proximo,
    output logic [ADDR_WIDTH-1:0] base_proximo,
    output logic [15:0]           quantum_restante,
    output logic                  ocioso
);

    typedef enum logic [1:0] {StOcioso, StExecuta, StTroca} estado_t;

    localparam logic [ADDR_WIDTH-1:0] BaseW    = ADDR_WIDTH'(BASE_PROG);
    localparam logic [ADDR_WIDTH-1:0] PassoW   = ADDR_WIDTH'(PASSO);
    localparam logic [ADDR_WIDTH-1:0] EndW     = ADDR_WIDTH'(END_TROCA);
    localparam logic [15:0]           QuantumW = 16'(QUANTUM);
    localparam logic [2:0]            UltimoW  = 3'(NUM_PROC - 1);

    estado_t               estado_q, estado_d;
    logic [2:0]            atual_q, atual_d, proximo_q, proximo_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, endereco_q, endereco_d;
    logic [15:0]           quantum_q, quantum_d;
    logic                  desvio_q, desvio_d, troca_req_q, troca_req_d, ocioso_q, ocioso_d;

    logic [7:0]            ativo_ext, mascara;
    logic                  cand_ok;
    logic [2:0]            cand;
    logic [ADDR_WIDTH-1:0] base_cand;
    logic                  expira, preempta;

    // Candidate search: walk downward so the last hit is the first slot after proc_atual.
    always_comb begin
        int idx;
        idx       = 0;
        ativo_ext = 8'(proc_ativo);
        mascara   = ativo_ext;
        if (estado_q == StExecuta && proc_fim) mascara[atual_q] = 1'b0;
        cand_ok = 1'b0;
        cand    = atual_q;
        for (int k = int'(NUM_PROC) - 1; k >= 0; k--) begin
            idx = int'(atual_q) + 1 + k;
            if (idx >= int'(NUM_PROC)) idx = idx - int'(NUM_PROC);
            if (mascara[idx[2:0]]) begin
                cand_ok = 1'b1;
                cand    = idx[2:0];
            end
        end
        base_cand = BaseW + {{(ADDR_WIDTH-3){1'b0}}, cand} * PassoW;
    end

    always_comb begin
        estado_d    = estado_q;
        atual_d     = atual_q;
        proximo_d   = proximo_q;
        base_d      = base_q;
        quantum_d   = quantum_q;
        desvio_d    = 1'b0;
        troca_req_d = troca_req_q;
        expira      = instr_exec && (quantum_q == 16'd1);
        preempta    = proc_fim || !ativo_ext[atual_q] || expira;

        unique case (estado_q)
            StOcioso: begin
                if (habilita && cand_ok) begin
                    proximo_d   = cand;
                    base_d      = base_cand;
                    desvio_d    = 1'b1;
                    troca_req_d = 1'b1;
                    estado_d    = StTroca;
                end
            end
            StTroca: begin
                if (troca_ack) begin
                    atual_d     = proximo_q;
                    quantum_d   = QuantumW;
                    troca_req_d = 1'b0;
                    estado_d    = StExecuta;
                end
            end
            StExecuta: begin
                if (!proc_fim && instr_exec && quantum_q != 16'd0) quantum_d = quantum_q - 16'd1;
                if (preempta) begin
                    if (!habilita || !cand_ok) begin
                        estado_d = StOcioso;
                    end else if (!proc_fim && ativo_ext[atual_q] && expira && cand == atual_q) begin
                        quantum_d = QuantumW;
                    end else begin
                        proximo_d   = cand;
                        base_d      = base_cand;
                        desvio_d    = 1'b1;
                        troca_req_d = 1'b1;
                        estado_d    = StTroca;
                    end
                end
            end
            default: estado_d = StOcioso;
        endcase

        ocioso_d   = (estado_d == StOcioso);
        endereco_d = desvio_d ? EndW : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= StOcioso;
            atual_q     <= UltimoW;
            proximo_q   <= 3'd0;
            base_q      <= BaseW;
            quantum_q   <= 16'd0;
            desvio_q    <= 1'b0;
            endereco_q  <= '0;
            troca_req_q <= 1'b0;
            ocioso_q    <= 1'b1;
        end else begin
            estado_q    <= estado_d;
            atual_q     <= atual_d;
            proximo_q   <= proximo_d;
            base_q      <= base_d;
            quantum_q   <= quantum_d;
            desvio_q    <= desvio_d;
            endereco_q  <= endereco_d;
            troca_req_q <= troca_req_d;
            ocioso_q    <= ocioso_d;
        end
    end

    assign desvio           = desvio_q;
    assign endereco_desvio  = endereco_q;
    assign troca_req        = troca_req_q;
    assign proc_atual       = atual_q;
    assign proc_proximo     = proximo_q;
    assign base_proximo     = base_q;
    assign quantum_restante = quantum_q;
    assign ocioso           = ocioso_q;

endmodule

// File: doc/escalonador_quantum.md
# escalonador_quantum

Preemptive round-robin scheduler that shares the processor between the user programs held in instruction memory. Program slot i starts at word address BASE_PROG + i*PASSO. The scheduler counts retired instructions of the running program against a quantum. On quantum expiry, program halt or program removal it requests a context switch: it forces the PC to the context-switch routine at END_TROCA and holds the selected next program until the routine acknowledges. It sits beside the PC/fetch logic, under OS control.

## Interface
- NUM_PROC, 5, number of program slots (1..8)
- QUANTUM, 16, instructions per time slice (1..65535)
- BASE_PROG, 2000, word address of program slot 0
- PASSO, 1000, word distance between program slots
- END_TROCA, 0, word address of the context-switch routine
- ADDR_WIDTH, 32, address width

- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- habilita  in  1  OS permits dispatching user programs
- proc_ativo  in  NUM_PROC  bit i=1: program i is ready
- instr_exec  in  1  one instruction of the running program retired this cycle
- proc_fim  in  1  running program executed halt this cycle
- troca_ack  in  1  context-switch routine finished (1-cycle pulse)
- desvio  out  1  1-cycle pulse: PC must load endereco_desvio
- endereco_desvio  out  ADDR_WIDTH  END_TROCA when desvio=1, else 0
- troca_req  out  1  high while a switch is pending acknowledgement
- proc_atual  out  3  index of the running program
- proc_proximo  out  3  index selected for the pending switch
- base_proximo  out  ADDR_WIDTH  BASE_PROG + proc_proximo*PASSO
- quantum_restante  out  16  instructions left in the current slice
- ocioso  out  1  high in state OCIOSO

## Operation
- States: OCIOSO, EXECUTA, TROCA. Reset values: state OCIOSO, proc_atual=NUM_PROC-1, proc_proximo=0, base_proximo=BASE_PROG, quantum_restante=0, desvio=0, endereco_desvio=0, troca_req=0, ocioso=1.
- Selection: the first set bit of proc_ativo, searching upward from (proc_atual+1) mod NUM_PROC with wrap-around. proc_atual itself is the last candidate. If no bit is set, "none".
- OCIOSO: if habilita=1 and a candidate exists: latch proc_proximo and base_proximo, pulse desvio, go to TROCA. Otherwise stay.
- TROCA: troca_req=1. proc_proximo and base_proximo are frozen. proc_ativo changes are ignored. On troca_ack: proc_atual<=proc_proximo, quantum_restante<=QUANTUM, troca_req<=0, go to EXECUTA.
- EXECUTA: instr_exec=1 decrements quantum_restante. A preemption event is any of:
  - proc_fim=1
  - proc_ativo[proc_atual]=0
  - instr_exec=1 with quantum_restante=1
- On a preemption event, with the current program excluded from selection when proc_fim=1 or its ready bit is clear:
  - habilita=0 or no candidate: go to OCIOSO, no desvio.
  - Quantum expiry and the candidate equals proc_atual (sole ready program): reload QUANTUM, stay in EXECUTA, no desvio.
  - Otherwise: latch proc_proximo/base_proximo, pulse desvio, go to TROCA.
- Priorities: proc_fim overrides instr_exec in the same cycle. troca_ack outside TROCA is ignored. instr_exec and proc_fim outside EXECUTA are ignored. quantum_restante never underflows below 0.
- Index arithmetic is modulo NUM_PROC. base_proximo is computed at ADDR_WIDTH, with no overflow for legal parameters.

## Timing
- All outputs are registered. desvio rises exactly 1 cycle after the edge that sampled the triggering event, lasts 1 cycle, and coincides with troca_req rising.
- troca_ack sampled at edge n: proc_atual updates and troca_req falls at edge n. The first counted instr_exec can arrive at edge n+1.
- Minimum switch latency: event -> desvio 1 cycle, then as long as the routine takes.
- reset asserted in any state returns to the reset values on the next edge. A pending switch is abandoned.

## Test plan
- Reset, habilita=1, proc_ativo=5'b00001 -> desvio pulse 1 cycle later, endereco_desvio=0, proc_proximo=0, base_proximo=2000. After troca_ack: proc_atual=0, quantum_restante=16.
- proc_ativo=5'b10101, running 0, 16 consecutive instr_exec -> desvio on the 16th, proc_proximo=2, base_proximo=4000. The next expiry selects 4, then 0 (wrap).
- Only program 3 ready, quantum expiry -> no desvio, quantum_restante reloads to 16, proc_atual stays 3.
- Running 1 with proc_ativo=5'b00011; proc_fim and instr_exec in the same cycle -> desvio, proc_proximo=0, quantum not decremented. Then clear all ready bits -> OCIOSO, ocioso=1.
- In TROCA, change proc_ativo and pulse instr_exec -> proc_proximo unchanged, no decrement. Assert reset mid-TROCA -> all outputs at reset values next cycle.
- habilita=0 during EXECUTA, then quantum expiry with other programs ready -> OCIOSO, no desvio. Re-raise habilita -> dispatch resumes from proc_atual+1.
